// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
//   Upstream command source for the I2C frame transmitter. An i_go rising edge
//   walks a table of (register address, data) entries. Each ordinary entry is
//   issued as one register-write frame through a level start/complete handshake.
//   Entries whose address equals DELAY_TAG insert a wait of data*DELAY_UNIT
//   cycles instead. A watchdog aborts a frame stuck in ISSUE/RELEASE.
//   The default table brings up a PCA9685 for 50 Hz PWM.
// Ports:
//   controller_clk  sequencer clock (same divided clock as the transmitter)
//   i_rst_n         asynchronous active-low reset
//   i_go            rising edge starts a sequence when idle
//   i_complete      completion flag from the frame transmitter
//   o_start         level-held start request to the transmitter
//   o_reg_addr      register address of the current entry
//   o_data          data byte of the current entry
//   o_busy          sequence in progress
//   o_done          sticky success flag, cleared by the next accepted i_go
//   o_error         sticky watchdog-abort flag, cleared by the next accepted i_go
//   o_index         current entry index (failing entry after an error)
module i2c_init_sequencer #(
   parameter int unsigned  N_ENTRIES   = 5,
   parameter logic [7:0]   DELAY_TAG   = 8'hFF,
   parameter int unsigned  DELAY_UNIT  = 1000,
   parameter int unsigned  GAP_CYC     = 4,
   parameter int unsigned  TIMEOUT_CYC = 4096,
   // Entry i occupies bits [16*i +: 16] as {reg_addr, data}.
   parameter logic [255:0] TABLE       = {176'h0, 16'h00A0, 16'hFF01,
                                          16'h0000, 16'hFE79, 16'h0010}
) (
   input  logic       controller_clk,
   input  logic       i_rst_n,
   input  logic       i_go,
   input  logic       i_complete,
   output logic       o_start,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic [3:0] o_index
);

   localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_ISSUE, S_RELEASE, S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
   } state_t;

   state_t             state;
   logic               go_q;
   logic               go_rise;
   logic [DLY_W-1:0]   dly_cnt;
   logic [WD_W-1:0]    wdog;
   logic [GAP_W-1:0]   gap_cnt;
   logic [15:0]        entry;
   logic               wd_expired;

   assign go_rise    = i_go & ~go_q;
   assign wd_expired = (wdog == WD_W'(TIMEOUT_CYC - 1));

   always_comb begin
      entry = TABLE[{o_index, 4'b0000} +: 16];
   end

   always_ff @(posedge controller_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         go_q       <= 1'b0;
         dly_cnt    <= '0;
         wdog       <= '0;
         gap_cnt    <= '0;
         o_start    <= 1'b0;
         o_reg_addr <= '0;
         o_data     <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_error    <= 1'b0;
         o_index    <= '0;
      end else begin
         go_q <= i_go;
         case (state)
            S_IDLE: begin
               o_busy <= 1'b0;
               if (go_rise) begin
                  o_done  <= 1'b0;
                  o_error <= 1'b0;
                  o_index <= '0;
                  o_busy  <= 1'b1;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               o_reg_addr <= entry[15:8];
               o_data     <= entry[7:0];
               if (entry[15:8] == DELAY_TAG) begin
                  if (entry[7:0] != 8'h00) begin
                     dly_cnt <= DLY_W'(entry[7:0]) * DLY_W'(DELAY_UNIT);
                     state   <= S_DELAY;
                  end else begin
                     state <= S_NEXT;
                  end
               end else begin
                  wdog    <= '0;
                  o_start <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            // Watchdog expiry is tested before i_complete so a late completion
            // arriving on the final allowed cycle still aborts.
            S_ISSUE: begin
               if (wd_expired) begin
                  o_start <= 1'b0;
                  state   <= S_ERROR;
               end else begin
                  wdog <= wdog + WD_W'(1);
                  if (i_complete) begin
                     o_start <= 1'b0;
                     state   <= S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               o_start <= 1'b0;
               if (wd_expired) begin
                  state <= S_ERROR;
               end else begin
                  wdog <= wdog + WD_W'(1);
                  if (!i_complete) begin
                     if (GAP_CYC == 0) begin
                        state <= S_NEXT;
                     end else begin
                        gap_cnt <= GAP_W'(GAP_CYC);
                        state   <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(1)) state <= S_NEXT;
               else                      gap_cnt <= gap_cnt - GAP_W'(1);
            end
            S_DELAY: begin
               if (dly_cnt == DLY_W'(1)) state <= S_NEXT;
               else                      dly_cnt <= dly_cnt - DLY_W'(1);
            end
            S_NEXT: begin
               if (o_index == 4'(N_ENTRIES - 1)) begin
                  state <= S_DONE;
               end else begin
                  o_index <= o_index + 4'd1;
                  state   <= S_LOAD;
               end
            end
            S_DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            S_ERROR: begin
               o_error <= 1'b1;
               o_busy  <= 1'b0;
               o_start <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer
//   Directed bench for i2c_init_sequencer. Instance a uses the default table;
//   instance b uses GAP_CYC=0 and a zero-length delay entry. A transmitter
//   model per instance raises i_complete 40 cycles after o_start rises and
//   drops it rel[d] cycles after o_start falls, logging every frame.
module tb_i2c_init_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] go;
   logic [1:0] comp = '0;
   logic [1:0] start, busy, done, err;
   logic [7:0] addr_a, data_a, addr_b, data_b;
   logic [3:0] idx_a, idx_b;

   int cyc = 0;
   int n_chk = 0, n_pass = 0, n_fail = 0;
   int hi[2] = '{0, 0};
   int lo[2] = '{0, 0};
   int hi_len[2] = '{0, 0};
   int fr_n[2] = '{0, 0};
   int fr_t[2][16];
   logic [15:0] fr_ad[2][16];
   int rel[2];
   int viol = 0;
   logic hang_en;
   logic [3:0] hang_idx;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   i2c_init_sequencer dut_a (
      .controller_clk(clk), .i_rst_n(rst_n), .i_go(go[0]), .i_complete(comp[0]),
      .o_start(start[0]), .o_reg_addr(addr_a), .o_data(data_a), .o_busy(busy[0]),
      .o_done(done[0]), .o_error(err[0]), .o_index(idx_a)
   );

   i2c_init_sequencer #(
      .N_ENTRIES(4),
      .GAP_CYC(0),
      .TABLE({192'h0, 16'h3033, 16'hFF00, 16'h2022, 16'h1011})
   ) dut_b (
      .controller_clk(clk), .i_rst_n(rst_n), .i_go(go[1]), .i_complete(comp[1]),
      .o_start(start[1]), .o_reg_addr(addr_b), .o_data(data_b), .o_busy(busy[1]),
      .o_done(done[1]), .o_error(err[1]), .o_index(idx_b)
   );

   // Transmitter model, evaluated on the falling edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (start[d]) begin
            if (hi[d] == 0) begin
               if (comp[d]) viol++;
               fr_ad[d][fr_n[d] % 16] = (d == 0) ? {addr_a, data_a} : {addr_b, data_b};
               fr_t[d][fr_n[d] % 16]  = cyc;
               fr_n[d]++;
            end
            hi[d]++;
            lo[d] = 0;
            if (hi[d] >= 40 && !(hang_en && d == 0 && idx_a == hang_idx)) comp[d] = 1'b1;
         end else begin
            if (hi[d] != 0) hi_len[d] = hi[d];
            hi[d] = 0;
            if (comp[d]) begin
               lo[d]++;
               if (lo[d] >= rel[d]) begin
                  comp[d] = 1'b0;
                  lo[d]   = 0;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int d);
      @(negedge clk);
      go[d] = 1'b1;
      @(negedge clk);
      go[d] = 1'b0;
   endtask

   task automatic wait_end(input int d, input int limit);
      int n = 0;
      while (!(done[d] || err[d]) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("wait_end_in_time", 32'(n < limit), 32'd1);
   endtask

   task automatic wait_frames(input int d, input int target, input int limit);
      int n = 0;
      while (fr_n[d] < target && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("wait_frames_in_time", 32'(n < limit), 32'd1);
   endtask

   function automatic int dt(input int d, input int i);
      return fr_t[d][(i + 1) % 16] - fr_t[d][i % 16];
   endfunction

   logic [15:0] exp_a[4] = '{16'h0010, 16'hFE79, 16'h0000, 16'h00A0};
   logic [15:0] exp_b[3] = '{16'h1011, 16'h2022, 16'h3033};

   initial begin
      int base;
      rst_n = 1'b0;
      go = '0;
      rel = '{2, 2};
      hang_en = 1'b0;
      hang_idx = 4'd1;

      // Reset values
      #2;
      chk("reset_outputs_a", 32'({start[0], busy[0], done[0], err[0], idx_a, addr_a, data_a}), 32'd0);
      chk("reset_outputs_b", 32'({start[1], busy[1], done[1], err[1], idx_b, addr_b, data_b}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Full default sequence
      base = fr_n[0];
      pulse(0);
      chk("t1_busy", 32'(busy[0]), 32'd1);
      chk("t1_index0", 32'(idx_a), 32'd0);
      wait_end(0, 3000);
      chk("t1_done", 32'({done[0], busy[0], err[0]}), 32'b100);
      chk("t1_nframes", 32'(fr_n[0] - base), 32'd4);
      for (int i = 0; i < 4; i++) chk("t1_frame", 32'(fr_ad[0][(base + i) % 16]), 32'(exp_a[i]));
      chk("t1_gap01", 32'(dt(0, base)), 32'd48);
      chk("t1_gap12", 32'(dt(0, base + 1)), 32'd48);
      chk("t1_gap23_delay", 32'(dt(0, base + 2)), 32'd1050);
      chk("t1_start_width", 32'(hi_len[0]), 32'd40);

      // i_go held high plus an extra mid-sequence pulse: one sequence only
      base = fr_n[0];
      @(negedge clk);
      go[0] = 1'b1;
      wait_frames(0, base + 2, 500);
      go[0] = 1'b0;
      @(negedge clk);
      go[0] = 1'b1;
      wait_end(0, 3000);
      repeat (100) @(negedge clk);
      chk("t2_nframes", 32'(fr_n[0] - base), 32'd4);
      chk("t2_idle_done", 32'({busy[0], done[0]}), 32'b01);
      go[0] = 1'b0;

      // Watchdog: no completion on entry 1
      hang_en = 1'b1;
      base = fr_n[0];
      pulse(0);
      wait_end(0, 6000);
      chk("t3_error_flags", 32'({err[0], done[0], busy[0], start[0]}), 32'b1000);
      chk("t3_index", 32'(idx_a), 32'd1);
      chk("t3_start_width", 32'(hi_len[0]), 32'd4096);
      chk("t3_nframes", 32'(fr_n[0] - base), 32'd2);
      hang_en = 1'b0;
      base = fr_n[0];
      pulse(0);
      chk("t3_restart_clears", 32'({err[0], busy[0], idx_a}), 32'({1'b0, 1'b1, 4'd0}));
      wait_end(0, 3000);
      chk("t3_restart_done", 32'(done[0]), 32'd1);
      chk("t3_restart_first", 32'(fr_ad[0][base % 16]), 32'h0010);

      // Slow completion release
      rel[0] = 500;
      base = fr_n[0];
      pulse(0);
      wait_frames(0, base + 2, 2000);
      chk("t4_slow_release_gap", 32'(dt(0, base)), 32'd546);
      wait_end(0, 5000);
      chk("t4_done", 32'(done[0]), 32'd1);
      rel[0] = 4100;
      base = fr_n[0];
      pulse(0);
      wait_end(0, 6000);
      chk("t4_release_timeout", 32'({err[0], done[0], idx_a}), 32'({1'b1, 1'b0, 4'd0}));
      chk("t4_nframes", 32'(fr_n[0] - base), 32'd1);
      for (int n = 0; n < 5000 && comp[0]; n++) @(negedge clk);
      chk("t4_complete_low", 32'(comp[0]), 32'd0);
      rel[0] = 2;

      // Asynchronous reset during entry 2
      base = fr_n[0];
      pulse(0);
      wait_frames(0, base + 3, 500);
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_start_async", 32'(start[0]), 32'd0);
      chk("t5_reset_outputs", 32'({busy[0], done[0], err[0], idx_a, addr_a, data_a}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base = fr_n[0];
      pulse(0);
      chk("t5_restart_index", 32'({busy[0], idx_a}), 32'({1'b1, 4'd0}));
      wait_frames(0, base + 1, 200);
      chk("t5_restart_first", 32'(fr_ad[0][base % 16]), 32'h0010);
      wait_end(0, 3000);
      chk("t5_done", 32'(done[0]), 32'd1);

      // GAP_CYC=0 and zero-length delay entry
      base = fr_n[1];
      pulse(1);
      wait_end(1, 2000);
      chk("t6_done", 32'({done[1], err[1], idx_b}), 32'({1'b1, 1'b0, 4'd3}));
      chk("t6_nframes", 32'(fr_n[1] - base), 32'd3);
      for (int i = 0; i < 3; i++) chk("t6_frame", 32'(fr_ad[1][(base + i) % 16]), 32'(exp_b[i]));
      chk("t6_back_to_back", 32'(dt(1, base)), 32'd44);
      chk("t6_zero_delay", 32'(dt(1, base + 1)), 32'd46);

      chk("no_start_during_complete", 32'(viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
